// File: rtl/score_pkg.sv
// Shared types and BCD helper for the score arbiter.
package score_pkg;

    localparam int unsigned N_SRC = 4;
    localparam int unsigned DIG_W = 4;

    typedef logic [DIG_W-1:0] bcd_digit_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADD  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // One BCD digit add; result is {carry_out, sum_digit}.
    function automatic logic [DIG_W:0] bcd_digit_add(input bcd_digit_t a,
                                                     input bcd_digit_t b,
                                                     input logic       cin);
        logic [DIG_W:0] s;
        s = {1'b0, a} + {1'b0, b} + {{DIG_W{1'b0}}, cin};
        if (s > 5'd9) bcd_digit_add = {1'b1, 4'(s - 5'd10)};
        else          bcd_digit_add = {1'b0, s[DIG_W-1:0]};
    endfunction

endpackage

// File: rtl/score_arbiter_if.sv
// Event-request / score bus between game logic (master) and the arbiter (slave).
interface score_arbiter_if;
    logic                        clear;
    logic [score_pkg::N_SRC-1:0] req;
    logic [15:0]                 score_bcd;
    logic [score_pkg::N_SRC-1:0] grant;
    logic                        busy;
    logic                        add_done;
    logic                        drop;
    logic                        sat;

    modport master (output clear, req,
                    input  score_bcd, grant, busy, add_done, drop, sat);
    modport slave  (input  clear, req,
                    output score_bcd, grant, busy, add_done, drop, sat);
endinterface

// File: rtl/rr_pick4.sv
// Combinational round-robin picker: first set mask bit at or above the pointer, modulo 4.
module rr_pick4
    import score_pkg::*;
(
    input  logic [N_SRC-1:0] i_mask,
    input  logic [1:0]       i_ptr,
    output logic [N_SRC-1:0] o_grant_c,
    output logic             o_valid_c
);

    logic [1:0] w_idx;

    // Walk from the farthest offset down so the nearest candidate wins.
    always_comb begin
        o_grant_c = '0;
        o_valid_c = 1'b0;
        w_idx     = '0;
        for (int k = N_SRC - 1; k >= 0; k--) begin
            w_idx = i_ptr + 2'(k);
            if (i_mask[w_idx]) begin
                o_grant_c        = '0;
                o_grant_c[w_idx] = 1'b1;
                o_valid_c        = 1'b1;
            end
        end
    end

endmodule

// File: rtl/score_arbiter.sv
// Round-robin BCD score adder shared by four event sources.
// SCORE_ARB_SAT_EN: clamp at 9999 on overflow instead of wrapping.
module score_arbiter
    import score_pkg::*;
#(
    parameter logic [15:0] W0     = 16'h0001,
    parameter logic [15:0] W1     = 16'h0005,
    parameter logic [15:0] W2     = 16'h0050,
    parameter logic [15:0] W3     = 16'h0100,
    parameter int unsigned PEND_W = 3
) (
    input  logic                  CLK_50M,
    input  logic                  RSTn,
    score_arbiter_if.slave        bus
);

`ifdef SCORE_ARB_SAT_EN
    localparam bit SAT_EN = 1'b1;
`else
    localparam bit SAT_EN = 1'b0;
`endif

    state_e            r_state, w_state_nxt;
    logic [N_SRC-1:0]  r_req_q, r_grant;
    logic [PEND_W-1:0] r_pend     [N_SRC];
    logic [PEND_W-1:0] w_pend_nxt [N_SRC];
    logic [1:0]        r_ptr, r_dig, w_gidx, w_pick_ptr;
    logic              r_carry, r_busy, r_add_done, r_drop, r_sat;
    logic [15:0]       r_score, w_weight;
    logic [N_SRC-1:0]  w_rise, w_dec, w_nz_now, w_nz_nxt, w_pick_mask, w_pick;
    logic              w_pick_vld, w_drop_set, w_hold;
    logic [DIG_W:0]    w_sum;

    assign w_rise = bus.req & ~r_req_q;
    assign w_dec  = (r_state == ST_DONE) ? r_grant : '0;
    assign w_hold = SAT_EN && r_sat;

    // Pending counters: rising edges queue, DONE retires; a coincident pair cancels.
    always_comb begin
        w_drop_set = 1'b0;
        for (int i = 0; i < N_SRC; i++) begin
            w_pend_nxt[i] = r_pend[i];
            if (w_rise[i] && !w_dec[i]) begin
                if (&r_pend[i]) w_drop_set = 1'b1;
                else            w_pend_nxt[i] = r_pend[i] + PEND_W'(1);
            end else if (w_dec[i] && !w_rise[i]) begin
                w_pend_nxt[i] = r_pend[i] - PEND_W'(1);
            end
            w_nz_now[i] = |r_pend[i];
            w_nz_nxt[i] = |w_pend_nxt[i];
        end
    end

    always_comb begin
        w_gidx = '0;
        for (int i = 0; i < N_SRC; i++) begin
            if (r_grant[i]) w_gidx = 2'(i);
        end
    end

    always_comb begin
        case (r_grant)
            4'b0001: w_weight = W0;
            4'b0010: w_weight = W1;
            4'b0100: w_weight = W2;
            4'b1000: w_weight = W3;
            default: w_weight = '0;
        endcase
    end

    // DONE re-arbitrates on the post-retire counts, starting just past the finished source.
    assign w_pick_mask = (r_state == ST_DONE) ? w_nz_nxt : w_nz_now;
    assign w_pick_ptr  = (r_state == ST_DONE) ? w_gidx + 2'd1 : r_ptr;

    rr_pick4 u_pick (
        .i_mask    (w_pick_mask),
        .i_ptr     (w_pick_ptr),
        .o_grant_c (w_pick),
        .o_valid_c (w_pick_vld)
    );

    assign w_sum = bcd_digit_add(r_score[{r_dig, 2'b00} +: 4],
                                 w_weight[{r_dig, 2'b00} +: 4], r_carry);

    always_ff @(posedge CLK_50M or negedge RSTn) begin
        if (!RSTn) r_state <= ST_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (w_pick_vld) w_state_nxt = ST_ADD;
            ST_ADD:  if (r_dig == 2'd3) w_state_nxt = ST_DONE;
            ST_DONE: w_state_nxt = w_pick_vld ? ST_ADD : ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
        if (bus.clear) w_state_nxt = ST_IDLE;
    end

    always_ff @(posedge CLK_50M or negedge RSTn) begin
        if (!RSTn) begin
            r_req_q    <= '0;
            r_grant    <= '0;
            r_ptr      <= '0;
            r_dig      <= '0;
            r_carry    <= 1'b0;
            r_score    <= '0;
            r_busy     <= 1'b0;
            r_add_done <= 1'b0;
            r_drop     <= 1'b0;
            r_sat      <= 1'b0;
            for (int i = 0; i < N_SRC; i++) r_pend[i] <= '0;
        end else begin
            r_req_q    <= bus.req;
            r_busy     <= (w_state_nxt != ST_IDLE);
            r_add_done <= (w_state_nxt == ST_DONE);
            if (bus.clear) begin
                r_grant <= '0;
                r_dig   <= '0;
                r_carry <= 1'b0;
                r_score <= '0;
                r_drop  <= 1'b0;
                r_sat   <= 1'b0;
                for (int i = 0; i < N_SRC; i++) r_pend[i] <= '0;
            end else begin
                r_pend <= w_pend_nxt;
                if (w_drop_set) r_drop <= 1'b1;
                case (r_state)
                    ST_IDLE: begin
                        if (w_pick_vld) r_grant <= w_pick;
                        r_dig   <= '0;
                        r_carry <= 1'b0;
                    end
                    ST_ADD: begin
                        r_dig   <= r_dig + 2'd1;
                        r_carry <= w_sum[DIG_W];
                        if (!w_hold) r_score[{r_dig, 2'b00} +: 4] <= w_sum[DIG_W-1:0];
                        if (r_dig == 2'd3 && w_sum[DIG_W]) begin
                            r_sat <= 1'b1;
                            if (SAT_EN) r_score <= 16'h9999;
                        end
                    end
                    ST_DONE: begin
                        r_ptr   <= w_gidx + 2'd1;
                        r_grant <= w_pick_vld ? w_pick : '0;
                        r_dig   <= '0;
                        r_carry <= 1'b0;
                    end
                    default: r_grant <= '0;
                endcase
            end
        end
    end

    assign bus.score_bcd = r_score;
    assign bus.grant     = r_grant;
    assign bus.busy      = r_busy;
    assign bus.add_done  = r_add_done;
    assign bus.drop      = r_drop;
    assign bus.sat       = r_sat;

endmodule
